div_iter: RTL and testbench

Parametrised iterative restoring divider for the EX-stage multicycle unit. Computes quotient and remainder of two WIDTH-bit operands, signed or unsigned, one quotient bit per cycle. Uses the start/abandon/ready handshake the pipeline already uses for multicycle ops. New in this generation:
- WIDTH is a parameter.
- Operands are latched at start.
- Explicit divide-by-zero flag and busy output.
- Optional leading-zero early-out.

---
 rtl/div_iter_if.sv | 34 +++
 rtl/div_iter.sv | 185 ++++++++++++++++++
 tb/tb_div_iter.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/div_iter_if.sv
`default_nettype none
// ============================================================================
//  Module      : div_iter_if
//  Description : Request/response bundle for the div_iter multicycle divider.
//                master : pipeline side (drives the request, reads the result)
//                slave  : divider side
//                divsigned/start/abandon/opr1/opr2 : request
//                busy/ready/dbz/res                : status and result
//  Revision    : 1.0  initial release
// ============================================================================
interface div_iter_if #(
  parameter int WIDTH = 32
);
  logic                 divsigned;
  logic                 start;
  logic                 abandon;
  logic [WIDTH-1:0]     opr1;
  logic [WIDTH-1:0]     opr2;
  logic                 busy;
  logic                 ready;
  logic                 dbz;
  logic [2*WIDTH-1:0]   res;

  modport master (
    output divsigned, start, abandon, opr1, opr2,
    input  busy, ready, dbz, res
  );

  modport slave (
    input  divsigned, start, abandon, opr1, opr2,
    output busy, ready, dbz, res
  );
endinterface
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : div_iter
//  Description : Iterative restoring divider, one quotient bit per cycle,
//                signed or unsigned WIDTH-bit operands.
//                clk  : clock, rising edge
//                rst  : synchronous active-high reset
//                bus  : div_iter_if.slave
//                       in  divsigned, start, abandon, opr1, opr2
//                       out busy, ready, dbz,
//                           res = {remainder, quotient}
//                Optional macro DIV_EARLY_OUT_EN: skip the leading-zero
//                iterations of the dividend magnitude.
//  Revision    : 1.0  initial release
// ============================================================================
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  div_iter_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] c_idle = 3'd0;
  localparam logic [2:0] c_byz  = 3'd1;
  localparam logic [2:0] c_run  = 3'd2;
  localparam logic [2:0] c_fix  = 3'd3;
  localparam logic [2:0] c_done = 3'd4;

  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  logic [2:0]         state_q, state_d;
  logic               neg1_q, neg1_d;   // dividend was negative (signed op)
  logic               neg2_q, neg2_d;   // divisor was negative (signed op)
  logic               byz_q, byz_d;     // result came from divide-by-zero
  logic [WIDTH-1:0]   dvd_q, dvd_d;     // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0]   dvs_q, dvs_d;     // divisor magnitude
  logic [WIDTH-1:0]   rem_q, rem_d;     // partial remainder
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               dbz_q, dbz_d;
  logic [2*WIDTH-1:0] res_q, res_d;

  logic [WIDTH-1:0]   mag1;
  logic [WIDTH-1:0]   mag2;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
`ifdef DIV_EARLY_OUT_EN
  logic [CW-1:0]      lz;
`endif

  always_comb begin
    state_d = state_q;
    neg1_d  = neg1_q;
    neg2_d  = neg2_q;
    byz_d   = byz_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    ready_d = 1'b0;
    dbz_d   = 1'b0;
    res_d   = '0;

    // Two's-complement negation of the most negative value yields itself,
    // which read as unsigned is exactly the required magnitude 2^(WIDTH-1).
    mag1 = (bus.divsigned && bus.opr1[WIDTH-1]) ? -bus.opr1 : bus.opr1;
    mag2 = (bus.divsigned && bus.opr2[WIDTH-1]) ? -bus.opr2 : bus.opr2;

    // One restoring step at WIDTH+1 bits; diff[WIDTH] is the sign.
    shifted = {rem_q, dvd_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};

`ifdef DIV_EARLY_OUT_EN
    // Ascending scan: the highest set bit writes last.
    lz = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (mag1[i]) lz = CW'(WIDTH - 1 - i);
    end
`endif

    case (state_q)
      c_idle: begin
        if (bus.start && !bus.abandon) begin
          neg1_d = bus.divsigned & bus.opr1[WIDTH-1];
          neg2_d = bus.divsigned & bus.opr2[WIDTH-1];
          dvs_d  = mag2;
          rem_d  = '0;
          byz_d  = 1'b0;
          if (bus.opr2 == '0) begin
            state_d = c_byz;
          end else begin
`ifdef DIV_EARLY_OUT_EN
            // Leading zeros would only shift zero quotient bits in, so
            // start the iteration as if they had already been consumed.
            dvd_d   = mag1 << lz;
            cnt_d   = lz;
            state_d = (lz == CW'(WIDTH)) ? c_fix : c_run;
`else
            dvd_d   = mag1;
            cnt_d   = '0;
            state_d = c_run;
`endif
          end
        end
      end

      c_byz: begin
        dvd_d   = '0;
        rem_d   = '0;
        byz_d   = 1'b1;
        state_d = c_done;
      end

      c_run: begin
        rem_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == c_last) state_d = c_fix;
      end

      c_fix: begin
        if (neg1_q ^ neg2_q) dvd_d = -dvd_q;
        if (neg1_q)          rem_d = -rem_q;
        state_d = c_done;
      end

      c_done: begin
        if (bus.start) begin
          ready_d = 1'b1;
          dbz_d   = byz_q;
          res_d   = {rem_q, dvd_q};
        end else begin
          state_d = c_idle;
        end
      end

      default: state_d = c_idle;
    endcase

    if (bus.abandon && (state_q != c_idle)) begin
      state_d = c_idle;
      ready_d = 1'b0;
      dbz_d   = 1'b0;
      res_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_idle;
      neg1_q  <= 1'b0;
      neg2_q  <= 1'b0;
      byz_q   <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      dbz_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      neg1_q  <= neg1_d;
      neg2_q  <= neg2_d;
      byz_q   <= byz_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      dbz_q   <= dbz_d;
      res_q   <= res_d;
    end
  end

  assign bus.busy  = (state_q != c_idle);
  assign bus.ready = ready_q;
  assign bus.dbz   = dbz_q;
  assign bus.res   = res_q;

endmodule
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_div_iter
//  Description : Directed self-checking bench for div_iter, WIDTH=32.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_div_iter;

  localparam int WIDTH = 32;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  div_iter_if #(.WIDTH(WIDTH)) bus ();

  div_iter #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected latency from the start edge, given the dividend's leading zeros.
  function automatic int exp_lat(input int lz);
`ifdef DIV_EARLY_OUT_EN
    return WIDTH - lz + 2;
`else
    return WIDTH + 2;
`endif
  endfunction

  task automatic do_op(input string tag, input logic sg, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp_res,
                       input logic exp_dbz, input int lat_exp);
    int lat;
    @(posedge clk); #1;
    bus.divsigned = sg;
    bus.opr1      = a;
    bus.opr2      = b;
    bus.start     = 1'b1;
    @(posedge clk); #1;   // edge 0
    // Operands are ignored after the start edge.
    bus.opr1      = ~a;
    bus.opr2      = b ^ 32'h5A5A_0001;
    bus.divsigned = ~sg;
    chk({tag, " busy"}, 64'(bus.busy), 64'd1);
    lat = 0;
    while (!bus.ready && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(lat_exp));
    chk({tag, " res"}, bus.res, exp_res);
    chk({tag, " dbz"}, 64'(bus.dbz), 64'(exp_dbz));
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk({tag, " clr"}, {61'd0, bus.ready, bus.dbz, bus.busy}, 64'd0);
    chk({tag, " res clr"}, bus.res, 64'd0);
  endtask

  initial begin
    int seen;
    n_total       = 0;
    n_bad         = 0;
    rst           = 1'b1;
    bus.divsigned = 1'b0;
    bus.start     = 1'b0;
    bus.abandon   = 1'b0;
    bus.opr1      = '0;
    bus.opr2      = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outs", {61'd0, bus.ready, bus.dbz, bus.busy}, 64'd0);
    chk("reset res", bus.res, 64'd0);
    rst = 1'b0;

    do_op("u 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, exp_lat(25));
    do_op("s -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, exp_lat(29));
    do_op("s 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 1'b0, exp_lat(29));
    do_op("s -7/-2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, {32'hFFFF_FFFF, 32'd3}, 1'b0, exp_lat(29));
    do_op("s 5/0", 1'b1, 32'd5, 32'd0, 64'd0, 1'b1, 2);
    do_op("u 5/0", 1'b0, 32'd5, 32'd0, 64'd0, 1'b1, 2);
    do_op("s min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0, exp_lat(0));
    do_op("u 3/1", 1'b0, 32'd3, 32'd1, {32'd0, 32'd3}, 1'b0, exp_lat(30));
    do_op("u 0/5", 1'b0, 32'd0, 32'd5, 64'd0, 1'b0, exp_lat(32));
    do_op("u max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 1'b0, exp_lat(0));
    do_op("u max/16", 1'b0, 32'hFFFF_FFFF, 32'd16, {32'd15, 32'h0FFF_FFFF}, 1'b0, exp_lat(0));

    // Abandon part-way through RUN.
    @(posedge clk); #1;
    bus.divsigned = 1'b0;
    bus.opr1      = 32'h1234_5678;
    bus.opr2      = 32'd3;
    bus.start     = 1'b1;
    @(posedge clk); #1;   // edge 0
    repeat (10) @(posedge clk);
    #1;
    chk("abandon pre busy", 64'(bus.busy), 64'd1);
    bus.abandon = 1'b1;
    bus.start   = 1'b0;
    @(posedge clk); #1;
    bus.abandon = 1'b0;
    chk("abandon outs", {61'd0, bus.ready, bus.dbz, bus.busy}, 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.ready || bus.busy) seen++;
    end
    chk("abandon quiet", 64'(seen), 64'd0);
    do_op("u 9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0, exp_lat(28));

    // Reset in the middle of RUN.
    @(posedge clk); #1;
    bus.divsigned = 1'b0;
    bus.opr1      = 32'h0100_0000;
    bus.opr2      = 32'd7;
    bus.start     = 1'b1;
    @(posedge clk); #1;   // edge 0
    repeat (3) @(posedge clk);
    #1;
    chk("rst pre busy", 64'(bus.busy), 64'd1);
    rst       = 1'b1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("rst outs", {61'd0, bus.ready, bus.dbz, bus.busy}, 64'd0);
    chk("rst res", bus.res, 64'd0);
    rst = 1'b0;
    do_op("u 1000/3", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 1'b0, exp_lat(22));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
